// File: rtl/any1_pkg.sv
// Shared types for the ANY1 memory sequencer: element sizes, FSM states, lane masks.
package any1_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_WYDE  = 2'd1,
        SZ_TETRA = 2'd2,
        SZ_OCTA  = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AGEN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_BUS   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic logic [7:0] size_mask(input size_e sz);
        case (sz)
            SZ_BYTE:  return 8'h01;
            SZ_WYDE:  return 8'h03;
            SZ_TETRA: return 8'h0F;
            default:  return 8'hFF;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input size_e sz);
        case (sz)
            SZ_BYTE:  return 3'b000;
            SZ_WYDE:  return 3'b001;
            SZ_TETRA: return 3'b011;
            default:  return 3'b111;
        endcase
    endfunction

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/any1_memseq_lane.sv
// Byte-lane steering: select mask, store-data shift-up and load-data shift-down/zero-extend.
// Purely combinational, zero latency, no flow control.
module any1_memseq_lane
    import any1_pkg::*;
(
    input  size_e       sz_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdat_i,
    input  logic [63:0] dat_i,
    output logic [7:0]  sel_o,
    output logic [63:0] wdat_o,
    output logic [63:0] rdat_o
);

    always_comb begin
        sel_o  = size_mask(sz_i) << off_i;
        wdat_o = wdat_i << {off_i, 3'b000};
        rdat_o = (dat_i >> {off_i, 3'b000}) & expand_mask(size_mask(sz_i));
    end

endmodule

// File: rtl/any1_memseq.sv
// Element-by-element load/store sequencer driving a single-beat bus; 3 cycles per zero-wait element.
// Bus stalls hold all strobe/address/data outputs until ack or err; no request queueing.
module any1_memseq
    import any1_pkg::*;
#(
    parameter int AWID  = 32,
    parameter int VLMAX = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_sz_i,
    input  logic [6:0]      req_vlen_i,
    output logic [5:0]      step_o,
    input  logic [AWID-1:0] ea_i,
    input  logic [63:0]     wdat_i,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [7:0]      sel_o,
    output logic [AWID-1:0] adr_o,
    output logic [63:0]     dat_o,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic [63:0]     dat_i,
    output logic [63:0]     rdat_o,
    output logic            rvalid_o,
    output logic [5:0]      relem_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o
);

    state_e      state_q;
    logic        we_q;
    size_e       sz_q;
    logic [6:0]  vlen_q;
    logic [2:0]  off_q;

    logic [6:0]  vlen_d;
    logic [2:0]  lane_off;
    logic        misaligned;
    logic        last_elem;
    logic [7:0]  lane_sel;
    logic [63:0] lane_wdat;
    logic [63:0] lane_rdat;

    always_comb begin
        vlen_d = req_vlen_i;
        if (req_vlen_i == 7'd0) begin
            vlen_d = 7'd1;
        end else if (req_vlen_i > 7'(VLMAX)) begin
            vlen_d = 7'(VLMAX);
        end
    end

    // Store steering uses the fresh address in ISSUE; load steering uses the offset latched with adr_o.
    assign lane_off   = (state_q == ST_ISSUE) ? ea_i[2:0] : off_q;
    assign misaligned = |(ea_i[2:0] & align_mask(sz_q));
    assign last_elem  = ({1'b0, step_o} == (vlen_q - 7'd1));
    assign busy_o     = (state_q != ST_IDLE);

    any1_memseq_lane u_lane (
        .sz_i   (sz_q),
        .off_i  (lane_off),
        .wdat_i (wdat_i),
        .dat_i  (dat_i),
        .sel_o  (lane_sel),
        .wdat_o (lane_wdat),
        .rdat_o (lane_rdat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            sz_q     <= SZ_BYTE;
            vlen_q   <= 7'd1;
            off_q    <= 3'd0;
            step_o   <= 6'd0;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            sel_o    <= 8'd0;
            adr_o    <= '0;
            dat_o    <= 64'd0;
            rdat_o   <= 64'd0;
            rvalid_o <= 1'b0;
            relem_o  <= 6'd0;
            done_o   <= 1'b0;
            fault_o  <= 1'b0;
        end else begin
            rvalid_o <= 1'b0;
            done_o   <= 1'b0;
            fault_o  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_i) begin
                        we_q    <= req_we_i;
                        sz_q    <= size_e'(req_sz_i);
                        vlen_q  <= vlen_d;
                        step_o  <= 6'd0;
                        state_q <= ST_AGEN;
                    end
                end
                ST_AGEN: begin
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (misaligned) begin
                        fault_o <= 1'b1;
                        done_o  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        adr_o   <= {ea_i[AWID-1:3], 3'b000};
                        off_q   <= ea_i[2:0];
                        sel_o   <= lane_sel;
                        dat_o   <= lane_wdat;
                        we_o    <= we_q;
                        cyc_o   <= 1'b1;
                        stb_o   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (err_i) begin
                        cyc_o   <= 1'b0;
                        stb_o   <= 1'b0;
                        fault_o <= 1'b1;
                        done_o  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (ack_i) begin
                        cyc_o <= 1'b0;
                        stb_o <= 1'b0;
                        if (!we_q) begin
                            rdat_o   <= lane_rdat;
                            relem_o  <= step_o;
                            rvalid_o <= 1'b1;
                        end
                        if (last_elem) begin
                            done_o  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            step_o  <= step_o + 6'd1;
                            state_q <= ST_AGEN;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_any1_memseq.sv
module tb_any1_memseq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_sz_i = 2'd0;
    logic [6:0]  req_vlen_i = 7'd0;
    logic [5:0]  step_o;
    logic [31:0] ea_i;
    logic [63:0] wdat_i;
    logic        cyc_o, stb_o, we_o;
    logic [7:0]  sel_o;
    logic [31:0] adr_o;
    logic [63:0] dat_o;
    logic        ack_i, err_i;
    logic [63:0] dat_i = 64'd0;
    logic [63:0] rdat_o;
    logic        rvalid_o;
    logic [5:0]  relem_o;
    logic        busy_o, done_o, fault_o;

    logic [31:0] ea_base = 32'd0;
    logic [31:0] ea_stride = 32'd8;
    logic [63:0] wdat_val = 64'd0;
    logic [7:0]  ack_delay = 8'd0;
    logic [7:0]  wait_cnt;
    logic        err_en = 1'b0;
    logic [5:0]  err_step = 6'd0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    any1_memseq #(.AWID(32), .VLMAX(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_i),
        .req_we_i   (req_we_i),
        .req_sz_i   (req_sz_i),
        .req_vlen_i (req_vlen_i),
        .step_o     (step_o),
        .ea_i       (ea_i),
        .wdat_i     (wdat_i),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .sel_o      (sel_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .dat_i      (dat_i),
        .rdat_o     (rdat_o),
        .rvalid_o   (rvalid_o),
        .relem_o    (relem_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .fault_o    (fault_o)
    );

    // Address generator and bus slave models
    assign ea_i   = ea_base + ea_stride * {26'd0, step_o};
    assign wdat_i = wdat_val;
    assign err_i  = stb_o && err_en && (step_o == err_step);
    assign ack_i  = stb_o && !err_i && (wait_cnt == ack_delay);

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 8'd0;
        else if (stb_o && !ack_i && !err_i) wait_cnt <= wait_cnt + 8'd1;
        else wait_cnt <= 8'd0;
    end

    // Activity monitor, sampled on the falling edge
    logic        mon_clr = 1'b0;
    int          rv_cnt, done_cnt, fault_cnt, stb_cyc, issue_cnt;
    logic        stb_prev;
    logic [5:0]  max_step;
    logic [5:0]  relem_log [0:63];
    logic [63:0] rdat_log  [0:63];
    logic [31:0] adr_log   [0:63];

    always @(negedge clk) begin
        if (mon_clr) begin
            rv_cnt = 0; done_cnt = 0; fault_cnt = 0; stb_cyc = 0; issue_cnt = 0;
            max_step = 6'd0; stb_prev = 1'b0;
        end else begin
            if (rvalid_o) begin
                relem_log[rv_cnt % 64] = relem_o;
                rdat_log[rv_cnt % 64]  = rdat_o;
                rv_cnt++;
            end
            if (done_o)  done_cnt++;
            if (fault_o) fault_cnt++;
            if (stb_o)   stb_cyc++;
            if (stb_o && !stb_prev) begin
                adr_log[issue_cnt % 64] = adr_o;
                issue_cnt++;
            end
            stb_prev = stb_o;
            if (busy_o && step_o > max_step) max_step = step_o;
        end
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic we, input logic [1:0] sz, input logic [6:0] vlen);
        req_we_i   = we;
        req_sz_i   = sz;
        req_vlen_i = vlen;
        req_i      = 1'b1;
        @(posedge clk);
        #1 req_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!busy_o) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        chk_cnt++;
        if ({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, rdat_o, rvalid_o, relem_o,
             step_o, busy_o, done_o, fault_o} !== '0)
            $display("FAIL reset_outputs: got nonzero output while rst high (stb=%b adr=%h step=%h busy=%b)",
                     stb_o, adr_o, step_o, busy_o);
        else pass_cnt++;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (busy_o !== 1'b0) $display("FAIL reset_idle: busy_o got %b expected 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_octa_load();
        bit to;
        clear_mon();
        ea_base = 32'h1000; ea_stride = 32'd8; ack_delay = 8'd0;
        dat_i = 64'h1122334455667788;
        start_req(1'b0, 2'd3, 7'd1);
        chk_cnt++;
        if (busy_o !== 1'b1 || step_o !== 6'd0)
            $display("FAIL octa_agen: busy/step got %b/%0d expected 1/0", busy_o, step_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (stb_o !== 1'b0) $display("FAIL octa_issue_stb: got %b expected 0", stb_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (stb_o !== 1'b1 || cyc_o !== 1'b1 || we_o !== 1'b0)
            $display("FAIL octa_bus_ctl: stb/cyc/we got %b%b%b expected 110", stb_o, cyc_o, we_o);
        else pass_cnt++;
        chk_cnt++;
        if (adr_o !== 32'h1000) $display("FAIL octa_adr: got %h expected 00001000", adr_o);
        else pass_cnt++;
        chk_cnt++;
        if (sel_o !== 8'hFF) $display("FAIL octa_sel: got %h expected ff", sel_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (rvalid_o !== 1'b1 || done_o !== 1'b1 || stb_o !== 1'b0)
            $display("FAIL octa_cycle4: rvalid/done/stb got %b%b%b expected 110", rvalid_o, done_o, stb_o);
        else pass_cnt++;
        chk_cnt++;
        if (rdat_o !== 64'h1122334455667788 || relem_o !== 6'd0)
            $display("FAIL octa_rdat: got %h elem %0d expected 1122334455667788 elem 0", rdat_o, relem_o);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (busy_o !== 1'b0 || done_o !== 1'b0)
            $display("FAIL octa_cycle5: busy/done got %b%b expected 00", busy_o, done_o);
        else pass_cnt++;
        wait_idle(10, to);
    endtask

    task automatic test_byte_store();
        bit to;
        clear_mon();
        ea_base = 32'h2005; ea_stride = 32'd1; wdat_val = 64'hAB;
        start_req(1'b1, 2'd0, 7'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_cnt++;
        if (adr_o !== 32'h2000 || sel_o !== 8'h20)
            $display("FAIL store_adr_sel: got %h/%h expected 00002000/20", adr_o, sel_o);
        else pass_cnt++;
        chk_cnt++;
        if (dat_o !== 64'h0000AB0000000000 || we_o !== 1'b1)
            $display("FAIL store_dat_we: got %h/%b expected 0000ab0000000000/1", dat_o, we_o);
        else pass_cnt++;
        wait_idle(20, to);
        chk_cnt++;
        if (to || done_cnt !== 1 || rv_cnt !== 0)
            $display("FAIL store_done: timeout %b done %0d rvalid %0d expected 0/1/0", to, done_cnt, rv_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wyde_vlen0();
        bit to;
        clear_mon();
        ea_base = 32'h4006; ea_stride = 32'd2; ack_delay = 8'd0;
        dat_i = 64'h1122334455667788;
        start_req(1'b0, 2'd1, 7'd0);
        wait_idle(20, to);
        chk_cnt++;
        if (to || issue_cnt !== 1 || rv_cnt !== 1)
            $display("FAIL vlen0_count: timeout %b issues %0d rvalid %0d expected 0/1/1", to, issue_cnt, rv_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (rdat_log[0] !== 64'h1122 || sel_o !== 8'hC0 || adr_log[0] !== 32'h4000)
            $display("FAIL wyde_steer: rdat %h sel %h adr %h expected 1122/c0/00004000", rdat_log[0], sel_o, adr_log[0]);
        else pass_cnt++;
    endtask

    task automatic test_vector_tetra();
        bit to;
        clear_mon();
        ea_base = 32'h100; ea_stride = 32'd8; ack_delay = 8'd2;
        dat_i = 64'hCAFEBABE12345678;
        start_req(1'b0, 2'd2, 7'd4);
        wait_idle(100, to);
        chk_cnt++;
        if (to) $display("FAIL vec_timeout: busy_o still %b after budget", busy_o);
        else pass_cnt++;
        chk_cnt++;
        if (rv_cnt !== 4 || done_cnt !== 1)
            $display("FAIL vec_pulses: rvalid %0d done %0d expected 4/1", rv_cnt, done_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (relem_log[0] !== 6'd0 || relem_log[1] !== 6'd1 || relem_log[2] !== 6'd2 || relem_log[3] !== 6'd3)
            $display("FAIL vec_relem: got %0d %0d %0d %0d expected 0 1 2 3",
                     relem_log[0], relem_log[1], relem_log[2], relem_log[3]);
        else pass_cnt++;
        chk_cnt++;
        if (issue_cnt !== 4 || stb_cyc !== 12)
            $display("FAIL vec_stb_hold: issues %0d stb cycles %0d expected 4/12", issue_cnt, stb_cyc);
        else pass_cnt++;
        chk_cnt++;
        if (adr_log[3] !== 32'h118 || rdat_log[3] !== 64'h12345678)
            $display("FAIL vec_elem3: adr %h rdat %h expected 00000118/12345678", adr_log[3], rdat_log[3]);
        else pass_cnt++;
        ack_delay = 8'd0;
    endtask

    task automatic test_misaligned();
        bit to;
        clear_mon();
        ea_base = 32'h3001; ea_stride = 32'd2;
        start_req(1'b0, 2'd1, 7'd1);
        wait_idle(20, to);
        chk_cnt++;
        if (to || issue_cnt !== 0 || stb_cyc !== 0)
            $display("FAIL misalign_nobus: timeout %b issues %0d expected 0/0", to, issue_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (fault_cnt !== 1 || done_cnt !== 1)
            $display("FAIL misalign_pulses: fault %0d done %0d expected 1/1", fault_cnt, done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_bus_error();
        bit to;
        clear_mon();
        ea_base = 32'h500; ea_stride = 32'd1; ack_delay = 8'd0;
        err_en = 1'b1; err_step = 6'd2;
        start_req(1'b0, 2'd0, 7'd5);
        wait_idle(100, to);
        err_en = 1'b0;
        chk_cnt++;
        if (to || fault_cnt !== 1 || done_cnt !== 1)
            $display("FAIL err_pulses: timeout %b fault %0d done %0d expected 0/1/1", to, fault_cnt, done_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (issue_cnt !== 3 || rv_cnt !== 2)
            $display("FAIL err_abandon: issues %0d rvalid %0d expected 3/2", issue_cnt, rv_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (max_step !== 6'd2 || step_o !== 6'd2)
            $display("FAIL err_step: max %0d final %0d expected 2/2", max_step, step_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_bus();
        bit seen;
        bit to;
        clear_mon();
        ea_base = 32'h600; ea_stride = 32'd8; ack_delay = 8'd30;
        start_req(1'b0, 2'd3, 7'd3);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (stb_o) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk_cnt++;
        if (!seen) $display("FAIL rstbus_stb_seen: stb_o never rose, got %b expected 1", stb_o);
        else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        chk_cnt++;
        if (stb_o !== 1'b0 || cyc_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL rstbus_async: stb/cyc/busy got %b%b%b expected 000", stb_o, cyc_o, busy_o);
        else pass_cnt++;
        #1 rst = 1'b0;
        ack_delay = 8'd0;
        start_req(1'b0, 2'd3, 7'd3);
        chk_cnt++;
        if (busy_o !== 1'b1 || step_o !== 6'd0)
            $display("FAIL rstbus_restart: busy/step got %b/%0d expected 1/0", busy_o, step_o);
        else pass_cnt++;
        wait_idle(100, to);
        chk_cnt++;
        if (to || rv_cnt !== 3 || relem_log[0] !== 6'd0)
            $display("FAIL rstbus_rerun: timeout %b rvalid %0d first elem %0d expected 0/3/0", to, rv_cnt, relem_log[0]);
        else pass_cnt++;
    endtask

    task automatic test_vlen_clamp();
        bit to;
        clear_mon();
        ea_base = 32'h0; ea_stride = 32'd1; ack_delay = 8'd0;
        start_req(1'b0, 2'd0, 7'd100);
        wait_idle(1000, to);
        chk_cnt++;
        if (to || issue_cnt !== 64 || rv_cnt !== 64)
            $display("FAIL clamp_count: timeout %b issues %0d rvalid %0d expected 0/64/64", to, issue_cnt, rv_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (max_step !== 6'd63 || done_cnt !== 1)
            $display("FAIL clamp_step: max step %0d done %0d expected 63/1", max_step, done_cnt);
        else pass_cnt++;
    endtask

    initial begin
        #12;
        test_reset();
        test_octa_load();
        test_byte_store();
        test_wyde_vlen0();
        test_vector_tetra();
        test_misaligned();
        test_bus_error();
        test_reset_mid_bus();
        test_vlen_clamp();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
